// File: rtl/program_memory_pkg.sv
// Shared definitions for the program_memory instruction store: FSM states,
// default geometry and the checksum rotate helper.
package program_memory_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int DEFAULT_INSTR_WIDTH = 16;
  localparam int DEFAULT_DEPTH       = 256;
  localparam int DEFAULT_INDEX_WIDTH = 32;

  // Widest word rotl1 handles; callers zero-extend into it and truncate back.
  localparam int ROTL_MAX_W = 64;

  function automatic logic [ROTL_MAX_W-1:0] rotl1(input logic [ROTL_MAX_W-1:0] x,
                                                 input int width);
    logic [ROTL_MAX_W-1:0] mask;
    mask = (ROTL_MAX_W'(1) << width) - ROTL_MAX_W'(1);
    return ((x << 1) | (x >> (width - 1))) & mask;
  endfunction

endpackage

// File: rtl/program_memory_ram.sv
// DEPTH x INSTR_WIDTH instruction array: one write port, one registered read port.
// Contents are never reset so a program survives a reset pulse.
module program_memory_ram
  import program_memory_pkg::*;
#(
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic                   re,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/program_memory.sv
// Instruction store between host download and CPU fetch. Optional image checksum
// is built only when PROGRAM_CHECKSUM_EN is defined; otherwise checksum is tied to 0.
module program_memory
  import program_memory_pkg::*;
#(
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   download_program,
  input  logic                   dl_valid,
  output logic                   dl_ready,
  input  logic                   dl_auto_inc,
  input  logic [INDEX_WIDTH-1:0] instruction_index,
  input  logic [INSTR_WIDTH-1:0] program_in,
  output logic [15:0]            dl_count,
  output logic                   dl_error,
  input  logic                   fetch_en,
  input  logic [INDEX_WIDTH-1:0] fetch_index,
  output logic [INSTR_WIDTH-1:0] fetch_data,
  output logic                   fetch_valid,
  output logic                   fetch_fault,
  output logic                   cpu_hold,
  output logic [INSTR_WIDTH-1:0] checksum,
  output state_t                 state
);

  localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [INDEX_WIDTH-1:0] DEPTH_IDX = INDEX_WIDTH'(DEPTH);

  // Download handshake: a word is taken on any cycle where dl_valid && dl_ready.
  // dl_ready is high exactly while in LOAD; there is no backpressure inside LOAD.
  logic [INDEX_WIDTH-1:0] ptr;
  logic [INDEX_WIDTH-1:0] target;
  logic                   wr_hs;
  logic                   wr_ok;
  logic                   rd_req;
  logic                   rd_ok;
  logic                   load_entry;
  logic [INSTR_WIDTH-1:0] rd_data;

  assign dl_ready   = (state == LOAD);
  assign cpu_hold   = (state != IDLE);
  assign target     = dl_auto_inc ? ptr : instruction_index;
  assign wr_hs      = dl_ready && dl_valid;
  assign wr_ok      = wr_hs && (target < DEPTH_IDX);
  assign rd_req     = (state == IDLE) && fetch_en && !download_program;
  assign rd_ok      = (fetch_index < DEPTH_IDX);
  assign load_entry = download_program && ((state == IDLE) || (state == RELEASE));

  // Unreset RAM read register is masked so fetch_data is 0 unless a good fetch is valid.
  assign fetch_data = (fetch_valid && !fetch_fault) ? rd_data : '0;

  program_memory_ram #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (target[ADDR_WIDTH-1:0]),
    .wdata (program_in),
    .re    (rd_req && rd_ok),
    .raddr (fetch_index[ADDR_WIDTH-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      dl_count    <= '0;
      dl_error    <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      fetch_valid <= rd_req;
      fetch_fault <= rd_req && !rd_ok;
      if (load_entry) begin
        ptr      <= instruction_index;
        dl_count <= '0;
        dl_error <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (download_program) state <= LOAD;
        end
        LOAD: begin
          if (wr_ok && (dl_count != 16'hFFFF)) dl_count <= dl_count + 16'd1;
          if (wr_hs && !wr_ok) dl_error <= 1'b1;
          // Pointer saturates rather than wrapping back into valid memory.
          if (wr_hs && dl_auto_inc && (ptr != '1)) ptr <= ptr + INDEX_WIDTH'(1);
          if (!download_program) state <= RELEASE;
        end
        RELEASE: begin
          state <= download_program ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PROGRAM_CHECKSUM_EN
  logic [INSTR_WIDTH-1:0] csum;

  always_ff @(posedge clk) begin
    if (!rst_n || load_entry) begin
      csum <= '0;
    end else if (wr_ok) begin
      csum <= INSTR_WIDTH'(rotl1(ROTL_MAX_W'(csum), INSTR_WIDTH)) ^ program_in;
    end
  end

  assign checksum = csum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_program_memory.sv
// Bench for program_memory: transaction-level model, fetch scoreboard with a
// separate monitor, directed scenarios followed by randomized download sessions.
module tb_program_memory;
  import program_memory_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 256;
  localparam int IW    = 32;
  localparam int EXP_W = 32 + 1 + W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           download_program = 1'b0;
  logic           dl_valid = 1'b0;
  logic           dl_ready;
  logic           dl_auto_inc = 1'b0;
  logic [IW-1:0]  instruction_index = '0;
  logic [W-1:0]   program_in = '0;
  logic [15:0]    dl_count;
  logic           dl_error;
  logic           fetch_en = 1'b0;
  logic [IW-1:0]  fetch_index = '0;
  logic [W-1:0]   fetch_data;
  logic           fetch_valid;
  logic           fetch_fault;
  logic           cpu_hold;
  logic [W-1:0]   checksum;
  state_t         state;

  program_memory #(.INSTR_WIDTH(W), .DEPTH(DEPTH), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .download_program(download_program),
    .dl_valid(dl_valid), .dl_ready(dl_ready), .dl_auto_inc(dl_auto_inc),
    .instruction_index(instruction_index), .program_in(program_in),
    .dl_count(dl_count), .dl_error(dl_error), .fetch_en(fetch_en),
    .fetch_index(fetch_index), .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .fetch_fault(fetch_fault), .cpu_hold(cpu_hold), .checksum(checksum), .state(state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [W-1:0]  mem_m [DEPTH];
  bit            written [DEPTH];
  int            wr_list[$];
  logic [IW-1:0] m_ptr;
  logic [15:0]   m_count;
  logic          m_err;
  logic [W-1:0]  m_csum;

  int checks = 0;
  int failures = 0;

  // Entries: {due_cycle[31:0], fault, data[W-1:0]}
  logic [EXP_W-1:0] exp_q[$];

  function automatic logic [W-1:0] csum_next(input logic [W-1:0] c, input logic [W-1:0] d);
`ifdef PROGRAM_CHECKSUM_EN
    return ((c << 1) | (c >> (W - 1))) ^ d;
`else
    return '0;
`endif
  endfunction

  task automatic model_enter(input logic [IW-1:0] seed);
    m_ptr = seed; m_count = '0; m_err = 1'b0; m_csum = '0;
  endtask

  task automatic model_write(input bit auto, input logic [IW-1:0] idx, input logic [W-1:0] data);
    logic [IW-1:0] t;
    t = auto ? m_ptr : idx;
    if (t < DEPTH) begin
      mem_m[t] = data;
      if (!written[t]) begin written[t] = 1'b1; wr_list.push_back(int'(t)); end
      if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      m_csum = csum_next(m_csum, data);
    end else begin
      m_err = 1'b1;
    end
    if (auto && m_ptr != '1) m_ptr = m_ptr + 32'd1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_dl_count"}, 32'(dl_count), 32'(m_count));
    chk({tag, "_dl_error"}, 32'(dl_error), 32'(m_err));
    chk({tag, "_checksum"}, 32'(checksum), 32'(m_csum));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    logic [31:0]      due;
    if (fetch_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_fetch_valid: got fetch_valid=1 expected 0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        due = e[EXP_W-1 -: 32];
        if ({fetch_fault, fetch_data} !== e[W:0] || cyc != due) begin
          failures++;
          $display("FAIL fetch_result: got fault=%0b data=0x%0h cyc=%0d expected fault=%0b data=0x%0h cyc=%0d",
                   fetch_fault, fetch_data, cyc, e[W], e[W-1:0], due);
        end
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q[0];
      due = e[EXP_W-1 -: 32];
      if (cyc >= due) begin
        void'(exp_q.pop_front());
        checks++;
        failures++;
        $display("FAIL missing_fetch_valid: got fetch_valid=%0b expected 1 at cyc %0d", fetch_valid, cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [IW-1:0] seed);
    download_program = 1'b1;
    instruction_index = seed;
    dl_valid = 1'b0;
    chk("ready_before_entry", 32'(dl_ready), 32'd0);
    chk("hold_before_entry", 32'(cpu_hold), 32'd0);
    tick();
    model_enter(seed);
    chk("entry_state", 32'(state), 32'(LOAD));
    chk("entry_ready", 32'(dl_ready), 32'd1);
    chk("entry_hold", 32'(cpu_hold), 32'd1);
    chk_counters("entry");
  endtask

  task automatic dl_write(input bit auto, input logic [IW-1:0] idx, input logic [W-1:0] data,
                          input bit last);
    dl_valid = 1'b1;
    dl_auto_inc = auto;
    instruction_index = idx;
    program_in = data;
    if (last) download_program = 1'b0;
    tick();
    dl_valid = 1'b0;
    model_write(auto, idx, data);
    chk_counters("write");
    if (last) begin
      chk("last_write_state", 32'(state), 32'(RELEASE));
      chk("last_write_ready", 32'(dl_ready), 32'd0);
    end
  endtask

  task automatic finish_release();
    chk("release_hold", 32'(cpu_hold), 32'd1);
    tick();
    chk("idle_state", 32'(state), 32'(IDLE));
    chk("idle_hold", 32'(cpu_hold), 32'd0);
    chk("idle_ready", 32'(dl_ready), 32'd0);
    chk_counters("idle");
  endtask

  task automatic end_load();
    download_program = 1'b0;
    tick();
    chk("release_state", 32'(state), 32'(RELEASE));
    chk("release_ready", 32'(dl_ready), 32'd0);
    finish_release();
  endtask

  task automatic fetch(input logic [IW-1:0] idx);
    logic [EXP_W-1:0] e;
    fetch_en = 1'b1;
    fetch_index = idx;
    if (idx < DEPTH) e = {32'(cyc + 1), 1'b0, mem_m[idx]};
    else             e = {32'(cyc + 1), 1'b1, {W{1'b0}}};
    exp_q.push_back(e);
    tick();
    fetch_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit last;
    model_enter('0);

    // Reset state
    tick(); tick();
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_ready", 32'(dl_ready), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    chk("rst_fetch_data", 32'(fetch_data), 32'd0);
    chk_counters("rst");
    rst_n = 1'b1;
    tick();

    // Explicit-index writes
    start_load(32'd0);
    dl_write(1'b0, 32'd10, 16'h2005, 1'b0);
    dl_write(1'b0, 32'd11, 16'h1FC2, 1'b0);
    end_load();
    chk("explicit_count", 32'(dl_count), 32'd2);
    fetch(32'd10);
    fetch(32'd11);
    tick();

    // Auto-increment across the top of memory
    start_load(32'd254);
    dl_write(1'b1, $urandom, 16'hAAAA, 1'b0);
    dl_write(1'b1, $urandom, 16'hBBBB, 1'b0);
    dl_write(1'b1, $urandom, 16'hCCCC, 1'b0);
    end_load();
    chk("auto_error", 32'(dl_error), 32'd1);
    chk("auto_count", 32'(dl_count), 32'd2);
    fetch(32'd254);
    fetch(32'd255);
    tick();

    // Fetch faults mixed with good fetches, back-to-back
    fetch(32'd300);
    fetch(32'd11);
    fetch(32'hFFFF_FFFF);
    fetch(32'd256);
    fetch(32'd255);
    tick();

    // Fetch ignored on entry cycle, during LOAD and RELEASE; re-entry clears state
    fetch_en = 1'b1;
    fetch_index = 32'd10;
    start_load(32'd20);
    dl_write(1'b1, 32'd0, 16'h1111, 1'b0);
    chk("load_fetch_valid", 32'(fetch_valid), 32'd0);
    dl_write(1'b0, 32'd400, 16'hDEAD, 1'b0);
    download_program = 1'b0;
    tick();
    chk("rel_state", 32'(state), 32'(RELEASE));
    chk("rel_fetch_valid", 32'(fetch_valid), 32'd0);
    download_program = 1'b1;
    instruction_index = 32'd30;
    tick();
    model_enter(32'd30);
    chk("reentry_state", 32'(state), 32'(LOAD));
    chk("reentry_fetch_valid", 32'(fetch_valid), 32'd0);
    chk_counters("reentry");
    fetch_en = 1'b0;
    dl_write(1'b1, $urandom, 16'h3333, 1'b0);
    end_load();
    fetch(32'd20);
    fetch(32'd30);
    tick();

    // Pointer saturation near all-ones; final write shares the exit cycle
    start_load(32'hFFFF_FFFE);
    repeat (3) dl_write(1'b1, 32'd0, 16'($urandom), 1'b0);
    dl_write(1'b0, 32'd12, 16'h5A5A, 1'b1);
    finish_release();
    chk("sat_count", 32'(dl_count), 32'd1);
    fetch(32'd12);
    fetch(32'd0);
    tick();

    // Checksum of two 0x0001 words
    start_load(32'd40);
    dl_write(1'b0, 32'd40, 16'h0001, 1'b0);
    dl_write(1'b0, 32'd41, 16'h0001, 1'b0);
`ifdef PROGRAM_CHECKSUM_EN
    chk("checksum_pair", 32'(checksum), 32'h0003);
`else
    chk("checksum_pair", 32'(checksum), 32'h0000);
`endif
    end_load();

    // Reset in the middle of LOAD keeps memory
    start_load(32'd0);
    dl_write(1'b0, 32'd5, 16'h1234, 1'b0);
    download_program = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_enter('0);
    chk("midrst_state", 32'(state), 32'(IDLE));
    chk("midrst_hold", 32'(cpu_hold), 32'd0);
    chk("midrst_ready", 32'(dl_ready), 32'd0);
    chk_counters("midrst");
    fetch(32'd5);
    tick();

    // Randomized download sessions followed by random fetch bursts
    repeat (8) begin
      start_load(IW'($urandom_range(0, 270)));
      n = $urandom_range(1, 8);
      last = 1'b0;
      for (int i = 0; i < n; i++) begin
        last = (i == n - 1) && ($urandom_range(0, 1) == 1);
        dl_write($urandom_range(0, 1) == 1, IW'($urandom_range(0, 299)), 16'($urandom), last);
      end
      if (last) finish_release();
      else end_load();
      repeat ($urandom_range(4, 10)) begin
        if ($urandom_range(0, 3) == 0) fetch(IW'($urandom_range(256, 1000)));
        else fetch(IW'(wr_list[$urandom_range(0, wr_list.size() - 1)]));
        if ($urandom_range(0, 4) == 0) tick();
      end
      tick();
    end

    tick(); tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
